instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 151 +++++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes decoded RV32I requests into instruction words and writes them to sequential imem slots.
// Optional build macro ENC_RANGE_CHECK_EN rejects immediates that the encoding would truncate.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [12:0] in_imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        full,
    output logic        err
);

    localparam int unsigned PtrW = $clog2(DEPTH) + 1;
    localparam logic [PtrW-1:0] PtrFull = PtrW'(DEPTH);

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StEncode, StWrite, StFull} state_e;

    state_e          state_q;
    logic [PtrW-1:0] ptr_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            full_q;
    logic            err_q;

    logic [2:0]      class_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [12:0]     imm_q;

    logic            accept;
    logic [31:0]     word;
    logic            class_bad;
    logic            range_bad;
    logic            illegal;
    logic [PtrW-1:0] ptr_inc;

    assign in_ready   = (state_q == StIdle);
    assign accept     = in_valid & in_ready;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign full       = full_q;
    assign err        = err_q;
    assign ptr_inc    = ptr_q + 1'b1;

    always_comb begin
        word      = '0;
        class_bad = 1'b0;
        case (class_q)
            3'd0: word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, 7'b0110011};
            3'd1: word = {imm_q[11:0], rs1_q, funct3_q, rd_q, 7'b0010011};
            3'd2: word = {imm_q[11:0], rs1_q, funct3_q, rd_q, 7'b0000011};
            3'd3: word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], 7'b0100011};
            3'd4: word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                          imm_q[4:1], imm_q[11], 7'b1100011};
            default: class_bad = 1'b1;
        endcase
    end

    // Only 12-bit immediates fit I/S forms; branch offsets must be even.
    always_comb begin
        range_bad = 1'b0;
        if ((class_q == 3'd1 || class_q == 3'd2 || class_q == 3'd3) && (imm_q[12] != imm_q[11])) begin
            range_bad = 1'b1;
        end
        if (class_q == 3'd4 && imm_q[0]) begin
            range_bad = 1'b1;
        end
        illegal = class_bad | (RangeCheck & range_bad);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            class_q  <= in_class;
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            imm_q    <= in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StEncode;
                    end
                end
                StEncode: begin
                    if (illegal) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        we_q    <= 1'b1;
                        addr_q  <= BASE_ADDR + 32'({ptr_q, 2'b00});
                        wdata_q <= word;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    we_q  <= 1'b0;
                    ptr_q <= ptr_inc;
                    if (ptr_inc == PtrFull) begin
                        full_q  <= 1'b1;
                        state_q <= StFull;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFull: begin
                    state_q <= StFull;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder, built with DEPTH=4 so the full condition is reachable.
module tb_instr_encoder;

    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [12:0] in_imm = '0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        full;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .BASE_ADDR(32'h0000_0000),
        .DEPTH    (Depth)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .full      (full),
        .err       (err)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm);
        in_class = cls; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Holds in_valid until accepted; returns one cycle after the accept edge (+1ns).
    task automatic send(output bit acc);
        acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Cycle index 0 is the cycle after accept, so a write at N+2 shows as first_at=1.
    task automatic collect(input int cycles, output int n_we, output int first_at,
                           output logic [31:0] a, output logic [31:0] d);
        n_we = 0; first_at = -1; a = '0; d = '0;
        for (int i = 0; i < cycles; i++) begin
            if (imem_we === 1'b1) begin
                if (n_we == 0) begin
                    first_at = i; a = imem_addr; d = imem_wdata;
                end
                n_we++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready_after_reset: got %b want 1", in_ready); end
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        send(acc);
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL addi_accept: got %b want 1", acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL addi_busy_ready: got %b want 0", in_ready); end
        collect(4, nw, fa, a, d);
        n_cmp++; if (nw !== 1) begin n_fail++; $display("FAIL addi_we_count: got %0d want 1", nw); end
        n_cmp++; if (fa !== 1) begin n_fail++; $display("FAIL addi_latency: got %0d want 1", fa); end
        n_cmp++; if (a !== 32'h0) begin n_fail++; $display("FAIL addi_addr: got %h want 00000000", a); end
        n_cmp++; if (d !== 32'h00500093) begin n_fail++; $display("FAIL addi_wdata: got %h want 00500093", d); end
    endtask

    task automatic test_sequence();
        bit acc; int nw, fa; logic [31:0] a, d;
        logic [2:0]  cls [3] = '{3'd2, 3'd3, 3'd0};
        logic [2:0]  f3  [3] = '{3'd2, 3'd2, 3'd0};
        logic [4:0]  rd  [3] = '{5'd2, 5'd0, 5'd3};
        logic [4:0]  rs2 [3] = '{5'd0, 5'd2, 5'd2};
        logic [12:0] imm [3] = '{13'd8, 13'd12, 13'd0};
        logic [31:0] exp_d [3] = '{32'h0080A103, 32'h0020A623, 32'h002081B3};
        logic [31:0] exp_a [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(cls[k], f3[k], 7'd0, rd[k], 5'd1, rs2[k], imm[k]);
            send(acc);
            n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL seq%0d_accept: got %b want 1", k, acc); end
            collect(3, nw, fa, a, d);
            n_cmp++; if (nw !== 1 || fa !== 1) begin n_fail++; $display("FAIL seq%0d_we: got count %0d at %0d want 1 at 1", k, nw, fa); end
            n_cmp++; if (a !== exp_a[k]) begin n_fail++; $display("FAIL seq%0d_addr: got %h want %h", k, a, exp_a[k]); end
            n_cmp++; if (d !== exp_d[k]) begin n_fail++; $display("FAIL seq%0d_wdata: got %h want %h", k, d, exp_d[k]); end
        end
    endtask

    task automatic test_branch();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        set_req(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        send(acc);
        collect(4, nw, fa, a, d);
        n_cmp++; if (nw !== 1) begin n_fail++; $display("FAIL beq_we_count: got %0d want 1", nw); end
        n_cmp++; if (d !== 32'hFE208EE3) begin n_fail++; $display("FAIL beq_wdata: got %h want FE208EE3", d); end
    endtask

    task automatic test_illegal();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        set_req(3'd6, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        send(acc);
        collect(4, nw, fa, a, d);
        n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL illegal_no_write: got %0d writes want 0", nw); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        send(acc);
        collect(4, nw, fa, a, d);
        n_cmp++; if (nw !== 1 || a !== 32'h0) begin n_fail++; $display("FAIL illegal_next_addr: got %0d writes at %h want 1 at 00000000", nw, a); end
        n_cmp++; if (d !== 32'h00500093) begin n_fail++; $display("FAIL illegal_next_wdata: got %h want 00500093", d); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_range();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h0800);
        send(acc);
        collect(4, nw, fa, a, d);
`ifdef ENC_RANGE_CHECK_EN
        n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL range_no_write: got %0d writes want 0", nw); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", err); end
`else
        n_cmp++; if (nw !== 1) begin n_fail++; $display("FAIL range_write: got %0d writes want 1", nw); end
        n_cmp++; if (d !== 32'h80000093) begin n_fail++; $display("FAIL range_wdata: got %h want 80000093", d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_err: got %b want 0", err); end
`endif
    endtask

    task automatic test_reset_mid();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        send(acc);
        collect(3, nw, fa, a, d);
        send(acc);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b want 0", imem_we); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err); end
        collect(4, nw, fa, a, d);
        n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes want 0", nw); end
        send(acc);
        collect(3, nw, fa, a, d);
        n_cmp++; if (nw !== 1 || a !== 32'h0) begin n_fail++; $display("FAIL rstmid_ptr: got %0d writes at %h want 1 at 00000000", nw, a); end
    endtask

    task automatic test_full();
        int n_acc = 0; int nw = 0;
        int w_cyc [8];
        logic [31:0] w_addr [8];
        do_reset();
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) n_acc++;
            if (imem_we === 1'b1) begin
                if (nw < 8) begin w_cyc[nw] = i; w_addr[nw] = imem_addr; end
                nw++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (n_acc !== 4) begin n_fail++; $display("FAIL full_accepts: got %0d want 4", n_acc); end
        n_cmp++; if (nw !== 4) begin n_fail++; $display("FAIL full_writes: got %0d want 4", nw); end
        for (int k = 0; k < 4 && k < nw; k++) begin
            n_cmp++; if (w_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL full_addr%0d: got %h want %h", k, w_addr[k], 32'(4 * k)); end
            if (k > 0) begin
                n_cmp++; if (w_cyc[k] - w_cyc[k-1] !== 3) begin n_fail++; $display("FAIL full_gap%0d: got %0d want 3", k, w_cyc[k] - w_cyc[k-1]); end
            end
        end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit acc; int nw, fa; logic [31:0] a, d;
        do_reset();
        set_req(3'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        send(acc);
        collect(3, nw, fa, a, d);
        set_req(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        for (int k = 0; k < 2; k++) begin
            send(acc);
            collect(3, nw, fa, a, d);
        end
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        n_cmp++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 00000000", imem_wdata); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    initial begin
        test_addi();
        test_sequence();
        test_branch();
        test_illegal();
        test_range();
        test_reset_mid();
        test_full();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
